// File: rtl/icache_refill_axi.sv
// Instruction-cache line refill engine: one 8-beat AXI3 INCR read burst per request,
// beats assembled into a line buffer that is presented to the cache with a one-cycle grant.
module icache_refill_axi #(
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        icache_rd_req,
   input  logic [31:0] icache_addr,
   output logic        icache_gnt,
   output logic [31:0] icache_data [0:7],
   output logic        refill_err,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  beat_cnt_reg;
   logic [26:0] addr_reg;
   logic        err_reg;
   logic [31:0] line_reg [0:7];
   logic        beat_take;

   // Handshake outputs come straight from the state register, never from AXI inputs.
   assign arvalid    = (state_reg == AR);
   assign rready     = (state_reg == R);
   assign icache_gnt = (state_reg == DONE);
   assign refill_err = (state_reg == DONE) && err_reg;
   assign beat_take  = (state_reg == R) && rvalid;

   assign arid    = AXI_ID;
   assign araddr  = {addr_reg, 5'b0};
   assign arlen   = 4'd7;
   assign arsize  = 3'b010;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

   // rid and rlast are deliberately ignored: the beat counter decides completion.
   logic unused_inputs;
   assign unused_inputs = ^{rid, rlast, icache_addr[4:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         beat_cnt_reg <= 3'd0;
         addr_reg     <= 27'd0;
         err_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && icache_rd_req) begin
            addr_reg     <= icache_addr[31:5];
            beat_cnt_reg <= 3'd0;
            err_reg      <= 1'b0;
         end else if (beat_take) begin
            beat_cnt_reg <= beat_cnt_reg + 3'd1;
            err_reg      <= err_reg | (rresp != 2'b00);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (icache_rd_req) state_next = AR;
         AR:      if (arready) state_next = R;
         R:       if (rvalid && beat_cnt_reg == 3'd7) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Line buffer words only change on an accepted beat, so data stays stable after the grant.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_line
         always_ff @(posedge clk) begin
            if (rst)
               line_reg[gi] <= 32'd0;
            else if (beat_take && beat_cnt_reg == 3'(gi))
               line_reg[gi] <= rdata;
         end
         assign icache_data[gi] = line_reg[gi];
      end
   endgenerate

endmodule
